// File: rtl/compare_seq_mag.sv
// rtl/compare_seq_mag.sv - multi-cycle MSB-first signed/unsigned magnitude comparator
// Define COMPARE_EARLY_EXIT_EN to leave BUSY on the first differing digit.
module compare_seq_mag #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_mode_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             a_lt_b_o,
  output logic             a_gt_b_o,
  output logic             a_eq_b_o
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int IDXW  = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, a_d, b_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [DIGIT-1:0] dig_a, dig_b;
  logic             dig_ne, dig_lt, accept, finish, fin_ne, fin_lt;
  logic             busy_q, done_q, lt_q, gt_q, eq_q;

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  assign a_d = {a_i[WIDTH-1] ^ signed_mode_i, a_i[WIDTH-2:0]};
  assign b_d = {b_i[WIDTH-1] ^ signed_mode_i, b_i[WIDTH-2:0]};

  // Operands shift left each step, so the current digit is always the top one.
  assign dig_a  = a_q[WIDTH-1 -: DIGIT];
  assign dig_b  = b_q[WIDTH-1 -: DIGIT];
  assign dig_ne = (dig_a != dig_b);
  assign dig_lt = (dig_a < dig_b);
  assign idx_d  = idx_q + IDXW'(1);
  assign accept = start_i && (state_q != BUSY);

`ifdef COMPARE_EARLY_EXIT_EN
  assign finish = dig_ne || (idx_q == LAST);
  assign fin_ne = dig_ne;
  assign fin_lt = dig_lt;
`else
  logic dec_q, slt_q;

  assign finish = (idx_q == LAST);
  assign fin_ne = dec_q | dig_ne;
  assign fin_lt = dec_q ? slt_q : dig_lt;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
`ifndef COMPARE_EARLY_EXIT_EN
      dec_q   <= 1'b0;
      slt_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q <= BUSY;
        busy_q  <= 1'b1;
        a_q     <= a_d;
        b_q     <= b_d;
        idx_q   <= '0;
`ifndef COMPARE_EARLY_EXIT_EN
        dec_q   <= 1'b0;
        slt_q   <= 1'b0;
`endif
      end else begin
        unique case (state_q)
          IDLE: state_q <= IDLE;
          BUSY: begin
            if (finish) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              lt_q    <= fin_ne & fin_lt;
              gt_q    <= fin_ne & ~fin_lt;
              eq_q    <= ~fin_ne;
            end else begin
              idx_q <= idx_d;
              a_q   <= a_q << DIGIT;
              b_q   <= b_q << DIGIT;
            end
`ifndef COMPARE_EARLY_EXIT_EN
            if (!dec_q && dig_ne) begin
              dec_q <= 1'b1;
              slt_q <= dig_lt;
            end
`endif
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign a_lt_b_o = lt_q;
  assign a_gt_b_o = gt_q;
  assign a_eq_b_o = eq_q;

endmodule

// File: doc/compare_seq_mag.md
Name: compare_seq_mag

Overview:
- Parametrised, multi-cycle magnitude comparator: successor of the 2-bit combinational comparators.
- Latches two WIDTH-bit operands on a start request and compares them MSB-first, DIGIT bits per cycle, in signed or unsigned mode.
- Reports exactly one of lt/gt/eq with a one-cycle done pulse.
- Sits between a register-file/datapath source and control logic that needs a comparison result at low area cost.

Parameters:
- WIDTH, 8, operand width in bits; must be >= 2 and an integer multiple of DIGIT.
- DIGIT, 2, bits compared per cycle; must be >= 1 and <= WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled on rising clk edge.
- a  input  WIDTH  operand A; sampled only when start is accepted.
- b  input  WIDTH  operand B; sampled only when start is accepted.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with a/b.
- busy  output  1  high while a comparison is in progress.
- done  output  1  one-cycle pulse; results valid and updated this cycle.
- a_lt_b  output  1  A < B (registered).
- a_gt_b  output  1  A > B (registered).
- a_eq_b  output  1  A == B (registered).

Behaviour:
- Reset (rst=1, any time, asynchronous): state=IDLE; busy=0, done=0, a_lt_b=0, a_gt_b=0, a_eq_b=0; digit index=0; any operation in flight is discarded, no done issued.
- STEPS = WIDTH/DIGIT. The digit index counter is ceil(log2(STEPS)) bits wide, minimum 1.
- States: IDLE, BUSY, DONE.
  - IDLE: start=1 -> latch a, b, signed_mode; index=0; go BUSY. start=0 -> stay.
  - BUSY: busy=1. Each cycle compare digit [WIDTH-1-index*DIGIT -: DIGIT] of the latched A and B as unsigned.
    - Digits differ -> register lt/gt from that digit, eq=0; go DONE.
    - Digits equal and index==STEPS-1 -> register eq=1, lt=0, gt=0; go DONE.
    - Otherwise index+1, stay BUSY.
  - DONE: done=1 for exactly one cycle; busy=0.
    - start=1 in DONE -> accepted (back-to-back): latch operands, go BUSY.
    - Otherwise go IDLE.
- Signed mode: operand MSBs are inverted at latch time. After that, an unsigned compare gives the two's-complement ordering. No other logic differs.
- start while BUSY is ignored. Operands are not re-sampled and there is no error indication.
- lt/gt/eq change only on the edge that enters DONE. They hold their value through IDLE and the next BUSY until the next DONE. After the first done, exactly one of them is 1.
- Latency, start-sampling edge to done-high cycle:
  - decision at digit k (0-based) -> k+2 cycles.
  - equal operands -> STEPS+1 cycles.
- Input a/b/signed_mode changes outside the accepting edge have no effect.

Optional Feature:
- Macro: COMPARE_EARLY_EXIT_EN.
- Defined: BUSY exits on the first differing digit, as above (data-dependent latency).
- Not defined: BUSY always runs all STEPS digits.
  - The first differing digit's lt/gt decision is recorded in internal sticky flags and later digits are ignored.
  - Result is registered on entering DONE after index==STEPS-1.
  - Latency is constant STEPS+1 cycles for every operand pair. Results are identical to the defined case.

Test Plan:
- Reset then idle: rst pulse, start=0 for 10 cycles -> busy=0, done=0, lt=gt=eq=0 throughout.
- Unsigned MSB-digit decision: WIDTH=8, DIGIT=2, a=8'hC0, b=8'h3F, signed_mode=0 -> a_gt_b=1, a_lt_b=0, a_eq_b=0.
  - Done 2 cycles after start with COMPARE_EARLY_EXIT_EN defined, 5 cycles without.
- Equal operands: a=b=8'h5A, unsigned -> done after 5 cycles in both builds; a_eq_b=1, a_lt_b=0, a_gt_b=0.
- Signed vs unsigned: a=8'hFF, b=8'h01.
  - signed_mode=1 -> a_lt_b=1 (-1 < 1).
  - Repeat back-to-back (start high in DONE) with signed_mode=0 -> a_gt_b=1; second done 2 cycles after the first (early-exit build).
- Start ignored and reset mid-operation:
  - a=8'h00, b=8'h00 start; pulse start again in BUSY with a=8'hFF -> result still a_eq_b=1, single done.
  - New op a=8'h01, b=8'h02; assert rst on the 2nd BUSY cycle -> immediate busy=0, outputs 0, no done pulse.
- Width sweep: WIDTH=16, DIGIT=4.
  - 1000 random pairs in each mode -> outputs match a reference ($signed/unsigned compare).
  - Exactly one of lt/gt/eq high at every done.
